// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port memory between fetch (I) and load/store (D) requesters.
// Each access takes grant -> BUSY (until mem_ack or watchdog) -> DONE (ack pulse), at least 3 cycles; requesters wait on req.
module mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_be,
    output logic          d_ack,
    output logic [31:0]   d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          last_d_q, last_d_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          err_q, err_d;
    logic [31:0]   wdog_q, wdog_d;

    logic grant_d;
    logic grant_i;
    logic expire;

    // D wins a tie only when I held the previous grant.
    assign grant_d = d_req & (~i_req | ~last_d_q);
    assign grant_i = i_req & ~grant_d;
    assign expire  = (TIMEOUT != 0) && (wdog_q == TIMEOUT - 1);

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        err_d       = 1'b0;
        wdog_d      = wdog_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d     = BUSY_D;
                    last_d_d    = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_be_d    = d_we ? d_be : 4'b0000;
                    wdog_d      = '0;
                end else if (grant_i) begin
                    state_d     = BUSY_I;
                    last_d_d    = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = 4'b0000;
                    wdog_d      = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (state_q == BUSY_I) begin
                        i_rdata_d = mem_rdata;
                        state_d   = DONE_I;
                    end else begin
                        d_rdata_d = mem_rdata;
                        state_d   = DONE_D;
                    end
                end else if (expire) begin
                    // Timed-out access completes with zero data and an error flag.
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (state_q == BUSY_I) begin
                        i_rdata_d = '0;
                        state_d   = DONE_I;
                    end else begin
                        d_rdata_d = '0;
                        state_d   = DONE_D;
                    end
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            DONE_I, DONE_D: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'b0000;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
            wdog_q      <= wdog_d;
        end
    end

    assign i_ack     = (state_q == DONE_I);
    assign d_ack     = (state_q == DONE_D);
    assign err       = err_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule
